// File: rtl/timer_device_pkg.sv
// timer_device_pkg: shared peripheral definitions (register map, CTRL fields, modes, FSM states)
package timer_device_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;
endpackage

// File: rtl/timer_device_if.sv
// timer_device_if: bridge-side register bus and interrupt line of the timer
interface timer_device_if #(parameter int WIDTH = 32);
    logic [1:0]       addr;
    logic             we;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             irq;
    modport master (output addr, we, din, input dout, irq);
    modport slave (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_device.sv
// timer_device: memory-mapped down-counting timer with one-shot/auto-reload modes and maskable irq
module timer_device
    import timer_device_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    timer_device_if.slave bus
);
    state_t           state, state_n;
    logic             en, en_n, im, flag, flag_n;
    logic [1:0]       mode;
    logic [WIDTH-1:0] preset, count, count_n;
    logic             ctrl_wr, pre_wr;

    assign ctrl_wr = bus.we && bus.addr == REG_CTRL;
    assign pre_wr  = bus.we && bus.addr == REG_PRESET;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            en     <= 1'b0;
            mode   <= MODE_ONESHOT;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            flag   <= 1'b0;
        end else begin
            state <= state_n;
            en    <= en_n;
            count <= count_n;
            flag  <= flag_n;
            if (ctrl_wr) begin
                mode <= bus.din[CTRL_MODE_MSB:CTRL_MODE_LSB];
                im   <= bus.din[CTRL_IM];
            end
            if (pre_wr)
                preset <= bus.din;
        end
    end

    always_comb begin
        state_n = state;
        en_n    = en;
        count_n = count;
        flag_n  = flag;
        case (state)
            S_IDLE: state_n = en ? S_LOAD : S_IDLE;
            S_LOAD: begin
                count_n = preset;
                state_n = S_CNT;
            end
            S_CNT: begin
                if (!en)
                    state_n = S_IDLE;
                else if (count == '0) begin
                    state_n = S_INT;
                    flag_n  = 1'b1;
                end else
                    count_n = count - WIDTH'(1);
            end
            default: begin
                // modes 2 and 3 fall back to one-shot behaviour
                state_n = (mode == MODE_AUTO) ? S_LOAD : S_IDLE;
                flag_n  = (mode == MODE_AUTO) ? 1'b0 : flag;
                en_n    = (mode == MODE_AUTO) ? en : 1'b0;
            end
        endcase
        // the CPU's write beats the FSM's own EN clear and flag update
        if (ctrl_wr) begin
            en_n   = bus.din[CTRL_EN];
            flag_n = 1'b0;
        end
    end

    assign bus.irq  = flag & im;
    assign bus.dout = (bus.addr == REG_CTRL)   ? WIDTH'({im, mode, en}) :
                      (bus.addr == REG_PRESET) ? preset :
                      (bus.addr == REG_COUNT)  ? count : '0;
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: randomized and directed scoreboard bench for timer_device
module tb_timer_device;
    import timer_device_pkg::*;

    typedef struct {
        string       nm;
        logic [31:0] d;
        logic        i;
    } exp_t;

    logic clk, reset;
    timer_device_if #(.WIDTH(32)) bus ();
    timer_device #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t sb[$];
    exp_t e;
    int   ncmp = 0;
    int   nfail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ncmp++;
            if (bus.dout !== e.d || bus.irq !== e.i) begin
                nfail++;
                $display("FAIL %s: got dout=%h irq=%b, expected dout=%h irq=%b", e.nm, bus.dout, bus.irq, e.d, e.i);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_i);
        exp_t x;
        bus.addr = a;
        bus.we   = w;
        bus.din  = d;
        x.nm = nm;
        x.d  = exp_d;
        x.i  = exp_i;
        sb.push_back(x);
        step();
        bus.we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.din  = d;
        step();
        bus.we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic void model(input int n, input bit auto_, input int t,
                                  output logic [31:0] cnt, output bit fired, output bit en);
        int u;
        if (auto_) begin
            en = 1'b1;
            if (t == 0) begin
                cnt   = 0;
                fired = 1'b0;
            end else begin
                u     = (t - 1) % (n + 3);
                fired = (u == n + 2);
                cnt   = (u == 0 || fired) ? 32'd0 : 32'(n - (u - 1));
            end
        end else begin
            en    = (t < n + 4);
            fired = (t >= n + 3);
            cnt   = (t < 2 || t > n + 2) ? 32'd0 : 32'(n - (t - 2));
        end
    endfunction

    task automatic run(input string tag, input int n, input logic [1:0] mode, input bit im,
                       input logic [31:0] pre, input int t0, input int t1, input bit rndw);
        logic [31:0] cnt, exp_d;
        bit          fired, en;
        logic [1:0]  a;
        logic        w;
        for (int t = t0; t <= t1; t++) begin
            model(n, mode == MODE_AUTO, t, cnt, fired, en);
            a = 2'($urandom_range(0, 3));
            w = rndw && a[1] && ($urandom_range(0, 3) == 0);
            exp_d = (a == REG_CTRL) ? {28'd0, im, mode, en} : (a == REG_PRESET) ? pre :
                    (a == REG_COUNT) ? cnt : 32'd0;
            chk($sformatf("%s t=%0d a=%0d", tag, t, a), a, w, $urandom, exp_d, im & fired);
        end
    endtask

    initial begin
        int          n;
        logic [1:0]  mode;
        bit          im;
        reset = 1'b1;
        bus.we = 1'b0;
        bus.addr = 2'd0;
        bus.din = '0;
        step();
        chk("rst ctrl", REG_CTRL, 0, 0, 0, 0);
        chk("rst preset", REG_PRESET, 0, 0, 0, 0);
        chk("rst count", REG_COUNT, 0, 0, 0, 0);
        chk("rst addr3", 2'd3, 0, 0, 0, 0);
        bus.addr = REG_CTRL;
        #1;
        ncmp++;
        if (bus.irq !== 1'b0 || bus.dout !== 32'd0) begin
            nfail++;
            $display("FAIL direct rst: dout=%h irq=%b", bus.dout, bus.irq);
        end
        reset = 1'b0;
        wr(REG_CTRL, 32'hFFFF_FFF8);
        chk("ctrl upper bits", REG_CTRL, 0, 0, 32'h8, 0);
        wr(REG_COUNT, 32'h0000_FFFF);
        chk("count write ignored", REG_COUNT, 0, 0, 0, 0);
        wr(2'd3, 32'h1234_5678);
        chk("addr3 reads 0", 2'd3, 0, 0, 0, 0);
        wr(REG_PRESET, 32'hA5A5_5A5A);
        chk("preset rw", REG_PRESET, 0, 0, 32'hA5A5_5A5A, 0);
        ncmp++;
        if (bus.dout !== 32'hA5A5_5A5A) begin
            nfail++;
            $display("FAIL direct preset: dout=%h", bus.dout);
        end

        do_reset();
        wr(REG_PRESET, 10);
        wr(REG_CTRL, 32'h9);
        run("pre-reset", 10, MODE_ONESHOT, 1, 10, 0, 4, 0);
        reset = 1'b1;
        bus.addr = REG_COUNT;
        #1;
        ncmp++;
        if (bus.dout !== 32'd0 || bus.irq !== 1'b0) begin
            nfail++;
            $display("FAIL direct midrst: dout=%h irq=%b", bus.dout, bus.irq);
        end
        chk("midrst count", REG_COUNT, 0, 0, 0, 0);
        chk("midrst ctrl", REG_CTRL, 0, 0, 0, 0);
        chk("midrst preset", REG_PRESET, 0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++)
            chk($sformatf("post-rst idle %0d", k), REG_CTRL, 0, 0, 0, 0);

        do_reset();
        wr(REG_PRESET, 5);
        wr(REG_CTRL, 32'h9);
        run("oneshot", 5, MODE_ONESHOT, 1, 5, 0, 12, 0);
        ncmp++;
        if (bus.irq !== 1'b1) begin
            nfail++;
            $display("FAIL direct oneshot irq held: irq=%b", bus.irq);
        end
        chk("oneshot ctrl", REG_CTRL, 0, 0, 32'h8, 1);
        wr(REG_CTRL, 32'h8);
        chk("oneshot irq drop", REG_CTRL, 0, 0, 32'h8, 0);
        ncmp++;
        if (bus.irq !== 1'b0) begin
            nfail++;
            $display("FAIL direct oneshot irq drop: irq=%b", bus.irq);
        end

        do_reset();
        wr(REG_PRESET, 3);
        wr(REG_CTRL, 32'hB);
        run("auto", 3, MODE_AUTO, 1, 3, 0, 20, 0);

        do_reset();
        wr(REG_PRESET, 2);
        wr(REG_CTRL, 32'h1);
        run("mask", 2, MODE_ONESHOT, 0, 2, 0, 7, 0);
        wr(REG_CTRL, 32'h9);
        run("unmask", 2, MODE_ONESHOT, 1, 2, 0, 8, 0);

        do_reset();
        wr(REG_PRESET, 9);
        wr(REG_CTRL, 32'h1);
        run("pause run", 9, MODE_ONESHOT, 0, 9, 0, 5, 0);
        wr(REG_CTRL, 32'h0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("pause hold %0d", k), REG_COUNT, 0, 0, 4, 0);
        chk("pause ctrl", REG_CTRL, 0, 0, 0, 0);
        wr(REG_CTRL, 32'h1);
        chk("resume t0", REG_COUNT, 0, 0, 4, 0);
        chk("resume t1", REG_COUNT, 0, 0, 4, 0);
        run("resume", 9, MODE_ONESHOT, 0, 9, 2, 14, 0);

        do_reset();
        wr(REG_PRESET, 6);
        wr(REG_CTRL, 32'h9);
        run("preset col a", 6, MODE_ONESHOT, 1, 6, 0, 2, 0);
        wr(REG_PRESET, 2);
        run("preset col b", 6, MODE_ONESHOT, 1, 2, 4, 11, 0);
        wr(REG_CTRL, 32'h9);
        run("preset next", 2, MODE_ONESHOT, 1, 2, 0, 8, 0);

        do_reset();
        wr(REG_PRESET, 2);
        wr(REG_CTRL, 32'h9);
        run("int col a", 2, MODE_ONESHOT, 1, 2, 0, 4, 0);
        wr(REG_CTRL, 32'h9);
        run("int col b", 2, MODE_ONESHOT, 1, 2, 0, 8, 0);

        for (int r = 0; r < 20; r++) begin
            do_reset();
            n    = $urandom_range(0, 12);
            mode = 2'($urandom_range(0, 3));
            im   = 1'($urandom_range(0, 1));
            wr(REG_PRESET, 32'(n));
            wr(REG_CTRL, {28'd0, im, mode, 1'b1});
            run($sformatf("rnd%0d n=%0d m=%0d im=%0d", r, n, mode, im), n, mode, im, 32'(n), 0, 2 * n + 12, 1);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
